fft_input_loader: RTL and testbench

Serial-to-parallel front end of the 32-point FFT. It accepts one real sample per handshake and writes each sample into a 32-slot frame buffer in bit-reversed order. It then presents the whole frame as one flat bus to the first butterfly stage, which consumes the samples as its 32 inputs `i_a0`..`i_a31`. The buffer is ping-pong (two banks), so bank B fills while bank A is held for the stage, and a bank is released only on an explicit frame acknowledge.

---
 rtl/fft_input_loader.sv | 135 +++++++++++++
 tb/tb_fft_input_loader.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_input_loader.sv
// fft_input_loader: serial-to-parallel front end of the 32-point FFT.
// Ping-pong frame buffer, bit-reversed writes, explicit frame release.
module fft_input_loader #(
  parameter int p_inputBits  = 9,
  parameter int p_points     = 32,
  parameter bit p_bitReverse = 1'b1
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic [p_inputBits-1:0]          i_sample,
  input  logic                            i_valid,
  output logic                            o_ready,
  output logic [p_points*p_inputBits-1:0] o_frame,
  output logic                            o_frame_valid,
  input  logic                            i_frame_ack,
  output logic [4:0]                      o_fill
);

  localparam int W = p_inputBits;
  localparam int N = p_points;

  logic [W-1:0] bank [2][N];

  logic       wr_sel;
  logic       rd_sel;
  logic [4:0] wr_cnt;
  logic       pending;
  logic       out_valid;

  logic       accept;
  logic       complete;
  logic [4:0] wr_slot;

  logic       do_swap;
  logic       do_stall;
  logic       do_release;
  logic       do_drain;

  function automatic logic [4:0] bitrev5(
    input logic [4:0] n
  );
    logic [4:0] r;
    for (int b = 0; b < 5; b++) begin
      r[b] = n[4-b];
    end
    return r;
  endfunction

  assign accept   = i_valid && !pending;
  assign complete = accept && (wr_cnt == 5'd31);

  // Write address: bit-reversed or natural slot for the current count
  always_comb begin
    wr_slot = wr_cnt;
    if (p_bitReverse) begin
      wr_slot = bitrev5(wr_cnt);
    end
  end

  // Mutually exclusive bank-pointer events
  always_comb begin
    do_swap    = complete && (!out_valid || i_frame_ack);
    do_stall   = complete && out_valid && !i_frame_ack;
    do_release = i_frame_ack && pending;
    do_drain   = i_frame_ack && out_valid
                 && !pending && !complete;
  end

  // Sample storage: the accepted sample lands in the write bank
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int b = 0; b < 2; b++) begin
        for (int k = 0; k < N; k++) begin
          bank[b][k] <= '0;
        end
      end
    end else if (accept) begin
      bank[wr_sel][wr_slot] <= i_sample;
    end
  end

  // Write counter, wraps 31 -> 0 on each completed frame
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_cnt <= '0;
    end else if (accept) begin
      wr_cnt <= wr_cnt + 5'd1;
    end
  end

  // Bank ownership: swap, stall, release and drain of the read bank
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_sel    <= 1'b0;
      rd_sel    <= 1'b0;
      pending   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      unique case (1'b1)
        do_swap: begin
          rd_sel    <= wr_sel;
          wr_sel    <= ~wr_sel;
          out_valid <= 1'b1;
        end
        do_stall: begin
          pending <= 1'b1;
        end
        do_release: begin
          rd_sel    <= wr_sel;
          wr_sel    <= ~wr_sel;
          pending   <= 1'b0;
          out_valid <= 1'b1;
        end
        do_drain: begin
          out_valid <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  // Presented frame is a plain mux of the read bank
  always_comb begin
    o_frame = '0;
    for (int k = 0; k < N; k++) begin
      o_frame[k*W +: W] = bank[rd_sel][k];
    end
  end

  assign o_ready       = !pending;
  assign o_frame_valid = out_valid;
  assign o_fill        = wr_cnt;

endmodule

// File: tb/tb_fft_input_loader.sv
// tb_fft_input_loader: scoreboard bench for the FFT input loader.
// Runs a bit-reversed and a natural-order instance side by side.
module tb_fft_input_loader;

  localparam int W  = 9;
  localparam int N  = 32;
  localparam int FW = N * W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [W-1:0]  i_sample = '0;
  logic          i_valid = 1'b0;
  logic          i_frame_ack = 1'b0;

  logic          ready;
  logic [FW-1:0] frame;
  logic          valid;
  logic [4:0]    fill;

  logic          ready_n;
  logic [FW-1:0] frame_n;
  logic          valid_n;
  logic [4:0]    fill_n;

  int checks = 0;
  int errors = 0;

  logic [FW-1:0] exp_q [$];
  logic [FW-1:0] nat_q [$];
  logic [FW-1:0] cur_br = '0;
  logic [FW-1:0] cur_nat = '0;
  int            cnt = 0;

  always #5 clk = ~clk;

  fft_input_loader #(
    .p_inputBits (W),
    .p_points    (N),
    .p_bitReverse(1'b1)
  ) dut (
    .CLK          (clk),
    .RST          (rst_n),
    .i_sample     (i_sample),
    .i_valid      (i_valid),
    .o_ready      (ready),
    .o_frame      (frame),
    .o_frame_valid(valid),
    .i_frame_ack  (i_frame_ack),
    .o_fill       (fill)
  );

  fft_input_loader #(
    .p_inputBits (W),
    .p_points    (N),
    .p_bitReverse(1'b0)
  ) dut_nat (
    .CLK          (clk),
    .RST          (rst_n),
    .i_sample     (i_sample),
    .i_valid      (i_valid),
    .o_ready      (ready_n),
    .o_frame      (frame_n),
    .o_frame_valid(valid_n),
    .i_frame_ack  (i_frame_ack),
    .o_fill       (fill_n)
  );

  function automatic int rev5(input int n);
    int r = 0;
    for (int b = 0; b < 5; b++) begin
      if (((n >> b) & 1) != 0) r |= 1 << (4 - b);
    end
    return r;
  endfunction

  task automatic chk(
    input string         tag,
    input logic [FW-1:0] got,
    input logic [FW-1:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ctl(
    input string tag,
    input logic  exp_ready,
    input logic  exp_valid
  );
    chk({tag, ".ready"}, FW'(ready), FW'(exp_ready));
    chk({tag, ".valid"}, FW'(valid), FW'(exp_valid));
    chk({tag, ".ready_n"}, FW'(ready_n), FW'(exp_ready));
    chk({tag, ".valid_n"}, FW'(valid_n), FW'(exp_valid));
  endtask

  task automatic send(
    input logic [W-1:0] s,
    input logic         ack
  );
    chk("send.ready", FW'(ready), FW'(1'b1));
    i_sample    = s;
    i_valid     = 1'b1;
    i_frame_ack = ack;
    tick();
    i_valid     = 1'b0;
    i_frame_ack = 1'b0;
    cur_br[rev5(cnt)*W +: W] = s;
    cur_nat[cnt*W +: W]      = s;
    cnt++;
    if (cnt == N) begin
      exp_q.push_back(cur_br);
      nat_q.push_back(cur_nat);
      cnt = 0;
    end
    chk("fill", FW'(fill), FW'(cnt));
    chk("fill_n", FW'(fill_n), FW'(cnt));
  endtask

  task automatic check_frame(input string tag);
    if (exp_q.size() == 0 || nat_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s got=frame exp=none queued", tag);
    end else begin
      chk({tag, ".br"}, frame, exp_q.pop_front());
      chk({tag, ".nat"}, frame_n, nat_q.pop_front());
    end
  endtask

  task automatic pulse_ack;
    i_frame_ack = 1'b1;
    tick();
    i_frame_ack = 1'b0;
  endtask

  task automatic chk_slot(input int k, input logic [W-1:0] exp);
    chk($sformatf("slot%0d", k), FW'(frame[k*W +: W]), FW'(exp));
  endtask

  initial begin
    #12;
    chk_ctl("reset", 1'b1, 1'b0);
    chk("reset.frame", frame, '0);
    chk("reset.fill", FW'(fill), '0);
    rst_n = 1'b1;
    tick();

    // single ramp frame
    for (int n = 0; n < N; n++) begin
      send(W'(n), 1'b0);
      if (n == N - 2) chk_ctl("ramp.pre", 1'b1, 1'b0);
    end
    chk_ctl("ramp.done", 1'b1, 1'b1);
    chk_slot(16, 9'd1);
    chk_slot(24, 9'd3);
    chk_slot(31, 9'd31);
    chk_slot(0, 9'd0);
    for (int k = 0; k < N; k++) begin
      chk($sformatf("nat%0d", k),
          FW'(frame_n[k*W +: W]), FW'(k));
    end
    check_frame("ramp");
    pulse_ack();
    chk_ctl("ramp.ack", 1'b1, 1'b0);

    // signed pass-through
    send(9'h100, 1'b0);
    send(9'h0FF, 1'b0);
    send(9'h1FF, 1'b0);
    for (int n = 3; n < N; n++) send(W'($urandom), 1'b0);
    chk_ctl("signed", 1'b1, 1'b1);
    chk_slot(0, 9'h100);
    chk_slot(16, 9'h0FF);
    chk_slot(8, 9'h1FF);
    check_frame("signed");
    pulse_ack();

    // stall: two frames without ack
    for (int n = 0; n < 2 * N; n++) send(W'($urandom), 1'b0);
    chk_ctl("stall", 1'b0, 1'b1);
    chk("stall.frame1", frame, exp_q[0]);
    i_sample = 9'h055;
    i_valid  = 1'b1;
    tick();
    i_valid  = 1'b0;
    chk("stall.drop", FW'(fill), '0);
    chk_ctl("stall.hold", 1'b0, 1'b1);
    check_frame("stall.f1");
    pulse_ack();
    chk_ctl("stall.ack", 1'b1, 1'b1);
    check_frame("stall.f2");
    pulse_ack();
    chk_ctl("stall.clear", 1'b1, 1'b0);

    // ack coincident with completion
    for (int n = 0; n < N; n++) send(W'($urandom), 1'b0);
    check_frame("simul.f1");
    for (int n = 0; n < N; n++) begin
      send(W'($urandom), n == N - 1);
      chk_ctl("simul.run", 1'b1, 1'b1);
    end
    check_frame("simul.f2");
    pulse_ack();
    chk_ctl("simul.clear", 1'b1, 1'b0);

    // reset mid-fill
    for (int n = 0; n < 10; n++) send(W'($urandom), 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_ctl("rst", 1'b1, 1'b0);
    chk("rst.frame", frame, '0);
    chk("rst.frame_n", frame_n, '0);
    chk("rst.fill", FW'(fill), '0);
    cnt = 0;
    cur_br = '0;
    cur_nat = '0;
    exp_q.delete();
    nat_q.delete();
    tick();
    rst_n = 1'b1;
    tick();
    for (int n = 0; n < N; n++) send(W'($urandom), 1'b0);
    chk_ctl("rst.frame1", 1'b1, 1'b1);
    check_frame("rst.f1");
    pulse_ack();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
